// File: rtl/seq_cfg_scheduler.sv
// Command scheduler: CPU writes queue tone/sweep codes in a small FIFO and an FSM
// issues each one as SETUP -> one-cycle STROBE -> HOLD. Optional SEQ_CFG_COALESCE_EN.
module seq_cfg_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_CYC   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic [7:0] freqin,
    output logic       sel_snd,
    output logic       sel_loop,
    output logic [7:0] kbd_out
);
    localparam int         PW        = $clog2(FIFO_DEPTH);
    localparam logic [3:0] DEPTH_C   = 4'(FIFO_DEPTH);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    typedef struct packed {
        logic       is_sweep;
        logic [3:0] code;
    } cmd_t;

    // Handshake: a CPU write (sel & we) is a single-cycle request that is always
    // accepted in the cycle it is presented; there is no ready/backpressure.
    // sel_snd/sel_loop are one-cycle fire-and-forget pulses with freqin already stable.
    state_t        state;
    cmd_t          fifo_mem [FIFO_DEPTH];
    cmd_t          push_cmd;
    cmd_t          head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [3:0]    count;
    logic [3:0]    last_tone;
    logic [3:0]    last_sweep;
    logic [7:0]    hold_cnt;
    logic          err;
    logic          ovf;
    logic          busy;
    logic          cur_sweep;
    logic          wr_en;
    logic          tone_ok;
    logic          tone_bad;
    logic          sweep_ok;
    logic          sweep_bad;
    logic          push_req;
    logic          coalesce;
    logic          push_ok;
    logic          overflow;
    logic          pop;

    assign wr_en     = sel & we;
    assign tone_ok   = wr_en && (addr == 2'd0) && (data_in <= 8'd15);
    assign tone_bad  = wr_en && (addr == 2'd0) && (data_in > 8'd15);
    assign sweep_ok  = wr_en && (addr == 2'd1) && (data_in <= 8'd7);
    assign sweep_bad = wr_en && (addr == 2'd1) && (data_in > 8'd7);
    assign push_req  = tone_ok | sweep_ok;
    assign push_cmd  = {sweep_ok, data_in[3:0]};
    assign head      = fifo_mem[rd_ptr];
    assign pop       = (state == IDLE) && (count != 4'd0);
    assign busy      = (state != IDLE);

`ifdef SEQ_CFG_COALESCE_EN
    logic [PW-1:0] newest_idx;
    assign newest_idx = wr_ptr - PW'(1);
    // The newest entry only counts if it survives this cycle's pop.
    assign coalesce = push_req && (count > {3'b000, pop}) &&
                      (fifo_mem[newest_idx].is_sweep == push_cmd.is_sweep);
`else
    assign coalesce = 1'b0;
`endif

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok  = push_req && !coalesce && ((count != DEPTH_C) || pop);
    assign overflow = push_req && !coalesce && !push_ok;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= push_cmd;
        end
`ifdef SEQ_CFG_COALESCE_EN
        if (coalesce) begin
            fifo_mem[newest_idx].code <= push_cmd.code;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err     <= 1'b0;
            ovf     <= 1'b0;
            kbd_out <= 8'd0;
        end else begin
            if (wr_en && (addr == 2'd3)) begin
                err <= 1'b0;
                ovf <= 1'b0;
            end else begin
                if (tone_bad || sweep_bad) err <= 1'b1;
                if (overflow)              ovf <= 1'b1;
            end
            if (wr_en && (addr == 2'd2)) kbd_out <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            freqin     <= 8'd0;
            sel_snd    <= 1'b0;
            sel_loop   <= 1'b0;
            hold_cnt   <= 8'd0;
            cur_sweep  <= 1'b0;
            last_tone  <= 4'd0;
            last_sweep <= 4'd0;
        end else begin
            sel_snd  <= 1'b0;
            sel_loop <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        freqin    <= {4'b0000, head.code};
                        cur_sweep <= head.is_sweep;
                        if (head.is_sweep) last_sweep <= head.code;
                        else               last_tone  <= head.code;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    sel_snd  <= !cur_sweep;
                    sel_loop <= cur_sweep;
                    state    <= STROBE;
                end
                STROBE: begin
                    hold_cnt <= 8'd0;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) state <= IDLE;
                    else                       hold_cnt <= hold_cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        data_out = 8'd0;
        case (addr)
            2'd0:    data_out = {4'b0000, last_tone};
            2'd1:    data_out = {4'b0000, last_sweep};
            2'd2:    data_out = kbd_out;
            default: data_out = {busy, 2'b00, count[2:0], ovf, err};
        endcase
    end
endmodule

// File: tb/tb_seq_cfg_scheduler.sv
// Bench for seq_cfg_scheduler: queue-based command model, scoreboard of expected
// strobes, per-cycle freqin/kbd_out checks and register read-back checks.
module tb_seq_cfg_scheduler;
    localparam int DEPTH = 4;
    localparam int HOLD  = 2;
    localparam int W     = 29;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       we;
    logic [1:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [7:0] freqin;
    logic       sel_snd;
    logic       sel_loop;
    logic [7:0] kbd_out;

    always #5 clk = ~clk;

    seq_cfg_scheduler #(.FIFO_DEPTH(DEPTH), .HOLD_CYC(HOLD)) dut (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .data_in(data_in),
        .data_out(data_out), .freqin(freqin), .sel_snd(sel_snd), .sel_loop(sel_loop),
        .kbd_out(kbd_out)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    bit mon_en     = 0;

    // Expected strobes: {strobe cycle[19:0], is_sweep, code[7:0]}
    logic [W-1:0] exp_q[$];

    // Reference model: a command queue plus "cycles until the scheduler is free again".
    logic [4:0] m_q[$];
    int         m_rem;
    logic       m_err, m_ovf;
    logic [7:0] m_kbd, m_freqin;
    logic [3:0] m_tone, m_sweep;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic logic [7:0] exp_reg(logic [1:0] a);
        case (a)
            2'd0:    return {4'b0000, m_tone};
            2'd1:    return {4'b0000, m_sweep};
            2'd2:    return m_kbd;
            default: return {m_rem != 0, 2'b00, 3'(m_q.size()), m_ovf, m_err};
        endcase
    endfunction

    task automatic model_step();
        logic [4:0] head;
        logic [4:0] cmd;
        bit         pop;
        bit         push;
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_rem = 0; m_err = 0; m_ovf = 0;
            m_kbd = 0; m_freqin = 0; m_tone = 0; m_sweep = 0;
            return;
        end
        pop = (m_rem == 0) && (m_q.size() > 0);
        if (pop) begin
            head     = m_q.pop_front();
            m_freqin = {4'b0000, head[3:0]};
            if (head[4]) m_sweep = head[3:0];
            else         m_tone  = head[3:0];
            m_rem = 2 + HOLD;
            exp_q.push_back({20'(cyc + 1), head[4], 4'b0000, head[3:0]});
        end else if (m_rem > 0) begin
            m_rem--;
        end
        push = 0;
        cmd  = '0;
        if (sel && we) begin
            case (addr)
                2'd0: if (data_in <= 15) begin push = 1; cmd = {1'b0, data_in[3:0]}; end
                      else m_err = 1;
                2'd1: if (data_in <= 7) begin push = 1; cmd = {1'b1, data_in[3:0]}; end
                      else m_err = 1;
                2'd2: m_kbd = data_in;
                default: begin m_err = 0; m_ovf = 0; end
            endcase
        end
        if (push) begin
`ifdef SEQ_CFG_COALESCE_EN
            if (m_q.size() > 0 && m_q[$][4] == cmd[4]) begin
                m_q[$] = cmd;
                push = 0;
            end
`endif
            if (push) begin
                if (m_q.size() < DEPTH) m_q.push_back(cmd);
                else                    m_ovf = 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    // Monitor: per-cycle output checks and strobe scoreboard.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("freqin", freqin, m_freqin);
                check("kbd_out", kbd_out, m_kbd);
                if (sel_snd || sel_loop) begin
                    check("strobe_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("strobe_cycle", cyc, e[28:9]);
                        check("strobe_kind", {sel_loop, sel_snd}, e[8] ? 2'b10 : 2'b01);
                        check("strobe_code", freqin, e[7:0]);
                    end
                end else if (exp_q.size() != 0 && int'(exp_q[0][28:9]) <= cyc) begin
                    e = exp_q.pop_front();
                    check("strobe_missing", cyc, e[28:9]);
                end
            end
        end
    end

    task automatic nop(int n);
        repeat (n) begin
            @(negedge clk);
            sel = 0; we = 0;
        end
    endtask

    task automatic wr(logic [1:0] a, logic [7:0] d);
        @(negedge clk);
        sel = 1; we = 1; addr = a; data_in = d;
    endtask

    task automatic rd(logic [1:0] a);
        @(negedge clk);
        sel = 1; we = 0; addr = a;
        #1;
        check($sformatf("data_out[%0d]", a), data_out, exp_reg(a));
    endtask

    task automatic wait_drained();
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            sel = 0; we = 0;
            if (m_rem == 0 && m_q.size() == 0) break;
        end
        check("drain_timeout", i < 200, 1);
    endtask

    task automatic wait_model_rem(int val);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            sel = 0; we = 0;
            if (m_rem == val) break;
        end
        check("wait_timeout", i < 200, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; sel = 0; we = 0; addr = 0; data_in = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        mon_en = 1;
        for (int a = 0; a < 4; a++) rd(2'(a));

        // Single tone issue
        wr(2'd0, 8'd5);
        nop(10);
        rd(2'd0); rd(2'd3);

        // Out-of-range sweep sets err, status write clears it
        wr(2'd1, 8'd9); nop(1); rd(2'd3); rd(2'd1);
        wr(2'd3, 8'hff); nop(1); rd(2'd3);
        wr(2'd0, 8'd16); nop(1); rd(2'd3);
        wr(2'd3, 8'h00); nop(1);

        // Overflow while the scheduler is busy
        wr(2'd0, 8'd9);
        for (int i = 1; i <= 5; i++) wr(2'd0, 8'(i));
        nop(1); rd(2'd3);
        wait_drained(); rd(2'd3); rd(2'd0);
        wr(2'd3, 8'd0); nop(1);

        // Full FIFO: push lands in the same cycle as a pop
        wr(2'd0, 8'd10);
        wr(2'd0, 8'd1); wr(2'd1, 8'd2); wr(2'd0, 8'd3); wr(2'd1, 8'd4);
        nop(1); rd(2'd3);
        wait_model_rem(0);
        wr(2'd0, 8'd12);
        rd(2'd3);
        wait_drained(); rd(2'd0); rd(2'd1);

        // Same-type back-to-back pushes (coalesce when enabled)
        wr(2'd0, 8'd11);
        wr(2'd0, 8'd3); wr(2'd0, 8'd7); wr(2'd1, 8'd2);
        nop(1); rd(2'd3);
        wait_drained(); rd(2'd0); rd(2'd1);

        // Reset during STROBE, overriding a simultaneous write
        wr(2'd2, 8'ha5); wr(2'd0, 8'd4);
        wait_model_rem(1 + HOLD);
        rst = 1; sel = 1; we = 1; addr = 2'd2; data_in = 8'h3c;
        @(negedge clk);
        rst = 0; sel = 0; we = 0;
        rd(2'd3); rd(2'd2); rd(2'd0);
        nop(10);

        // Randomized traffic
        for (int n = 0; n < 700; n++) begin
            int r;
            @(negedge clk);
            r       = $urandom_range(0, 199);
            rst     = (r == 0);
            sel     = (r < 70);
            we      = ($urandom_range(0, 3) != 0);
            addr    = 2'($urandom_range(0, 3));
            data_in = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15))
                                                 : 8'($urandom_range(0, 255));
            #1;
            check("rand_data_out", data_out, exp_reg(addr));
        end
        @(negedge clk);
        rst = 0; sel = 0; we = 0;
        wait_drained();
        nop(5);
        check("pending_strobes", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
